// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_pkg: shared definitions for the frame-buffer read engine.
//   ADDRL_DEF : default buffer address width (buffer depth = 2**ADDRL bytes)
//   lenw_of   : length-field width for a given address width (ADDRL+1), so a
//               transfer covering the whole buffer can be expressed
//   state_t   : control FSM states
package ram_stream_pkg;

    localparam int ADDRL_DEF = 14;

    function automatic int lenw_of(input int addrl);
        return addrl + 1;
    endfunction

    localparam int LENW_DEF = lenw_of(ADDRL_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, buffer read port and byte stream of the
// frame-buffer read engine.
//   command : start, start_addr, length -> busy, done
//   buffer  : ram_enb, ram_addrb -> ram_dob (one-cycle read latency)
//   stream  : out_valid, out_data, out_last -> out_ready
// master = the read engine, slave = its environment (command source, buffer
// and the byte consumer).
interface ram_stream_reader_if
    import ram_stream_pkg::*;
#(
    parameter int ADDRL = ADDRL_DEF,
    parameter int LENW  = ADDRL + 1
) ();

    logic             start;
    logic [ADDRL-1:0] start_addr;
    logic [LENW-1:0]  length;
    logic             busy;
    logic             done;

    logic             ram_enb;
    logic [ADDRL-1:0] ram_addrb;
    logic [7:0]       ram_dob;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;

    modport master (
        input  start, start_addr, length, ram_dob, out_ready,
        output busy, done, ram_enb, ram_addrb, out_valid, out_data, out_last
    );

    modport slave (
        output start, start_addr, length, ram_dob, out_ready,
        input  busy, done, ram_enb, ram_addrb, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ram_stream_reader_fifo.sv
// byte_skid_fifo: 2-entry, 8-bit FIFO absorbing stream backpressure.
//   clk, rst : clock, asynchronous active-high reset (storage cleared to 0)
//   push,din : write a byte at the end of the cycle
//   pop      : drop the head byte at the end of the cycle
//   count    : current occupancy (0..2)
//   head     : oldest byte; meaningful when count != 0
// Push and pop in the same cycle are legal at any occupancy; a push into a
// full FIFO is only honoured when a pop frees the slot in the same cycle.
module byte_skid_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [1:0] count,
    output logic [7:0] head
);

    logic [7:0] mem_reg [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    // When full, the write slot equals the head slot; overwriting it is safe
    // because the head leaves on the same edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_reg[gi] <= 8'h00;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side engine of the byte-wide frame buffer.
// On an accepted start it reads `length` bytes from start_addr upward
// (wrapping at the top of the buffer) and streams them out on a valid/ready
// byte interface; a 2-entry skid FIFO absorbs consumer backpressure.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ram_stream_reader_if.master (command, buffer read port, stream)
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDRL = ADDRL_DEF,
    parameter int LENW  = lenw_of(ADDRL)
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_stream_reader_if.master  bus
);

    state_t           state_reg;
    state_t           state_next;
    logic [ADDRL-1:0] rd_addr_reg;
    logic [LENW-1:0]  rd_left_reg;
    logic [LENW-1:0]  out_left_reg;
    logic             dob_vld_reg;

    logic [1:0]       fifo_count;
    logic [7:0]       fifo_head;
    logic             out_valid;
    logic             pop;
    logic             issue;
    logic             accept;
    logic [2:0]       occ;
    logic             busy;
    logic             done;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && bus.out_ready;
    assign accept    = (state_reg == IDLE) && bus.start;

    // Bytes held or in flight. A read is issued only if, after this cycle's
    // pop, at most one slot is committed, so the returning byte always fits.
    assign occ   = {1'b0, fifo_count} + {2'b00, dob_vld_reg};
    assign issue = (state_reg == RUN) && (rd_left_reg != '0) &&
                   (occ <= (3'd1 + {2'b00, pop}));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = (bus.length != '0) ? RUN : FINISH;
            end
            RUN: begin
                if (pop && (out_left_reg == LENW'(1))) state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:     busy = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Read address / remaining counters and the read-data-valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_reg  <= '0;
            rd_left_reg  <= '0;
            out_left_reg <= '0;
            dob_vld_reg  <= 1'b0;
        end else begin
            if (accept && (bus.length != '0)) begin
                rd_addr_reg  <= bus.start_addr;
                rd_left_reg  <= bus.length;
                out_left_reg <= bus.length;
            end else begin
                if (issue) begin
                    rd_addr_reg <= rd_addr_reg + 1'b1;
                    rd_left_reg <= rd_left_reg - 1'b1;
                end
                if (pop) out_left_reg <= out_left_reg - 1'b1;
            end
            dob_vld_reg <= issue;
        end
    end

    byte_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dob_vld_reg),
        .din   (bus.ram_dob),
        .pop   (pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.ram_enb   = issue;
    assign bus.ram_addrb = rd_addr_reg;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = fifo_head;
    assign bus.out_last  = out_valid && (out_left_reg == LENW'(1));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural buffer model and a
// scoreboard of expected read addresses and streamed bytes.
module tb_ram_stream_reader;

    localparam int ADDRL = 14;
    localparam int LENW  = 15;
    localparam int DEPTH = 1 << ADDRL;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_stream_reader_if #(.ADDRL(ADDRL), .LENW(LENW)) bus ();

    ram_stream_reader #(.ADDRL(ADDRL), .LENW(LENW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Buffer model: one-cycle read latency
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_enb) bus.ram_dob <= mem[bus.ram_addrb];
    end

    exp_t             exp_q[$];
    logic [ADDRL-1:0] addr_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int occ, pops, dones, enbs, valids, busys;
    int first_enb, first_valid, last_pop, done_c, start_cyc;
    logic       stall_prev;
    logic [7:0] stall_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        addr_q.delete();
        occ = 0; pops = 0; dones = 0; enbs = 0; valids = 0; busys = 0;
        first_enb = -1; first_valid = -1; last_pop = -1; done_c = -1;
        stall_prev = 1'b0;
        stall_data = 8'h00;
    endtask

    // One clock cycle: observe at the falling edge, then return 1ns after
    // the rising edge so the caller can drive the next cycle's inputs.
    task automatic cycle();
        logic p;
        exp_t e;
        @(negedge clk);
        p = bus.out_valid && bus.out_ready;
        if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data", 32'(bus.out_data), 32'(stall_data));
        end
        if (bus.out_valid) begin
            valids++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (bus.busy) busys++;
        if (bus.ram_enb) begin
            enbs++;
            if (first_enb < 0) first_enb = cyc;
            chk("enb_occupancy", 32'(occ <= 1 + int'(p)), 1);
            if (addr_q.size() == 0) chk("unexpected_read", addr_q.size(), 1);
            else chk("ram_addrb", 32'(bus.ram_addrb), 32'(addr_q.pop_front()));
        end
        if (p) begin
            pops++;
            if (bus.out_last) last_pop = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e.data));
                chk("out_last", 32'(bus.out_last), 32'(e.last));
                $display("byte %02h last=%0d cycle=%0d", bus.out_data, bus.out_last, cyc);
            end
        end
        if (bus.done) begin
            dones++;
            done_c = cyc;
            chk("done_busy", 32'(bus.busy), 0);
        end
        occ = occ + int'(bus.ram_enb) - int'(p);
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic start_xfer(input logic [ADDRL-1:0] addr, input int len, input bit model);
        logic [ADDRL-1:0] a;
        exp_t e;
        if (model) begin
            for (int i = 0; i < len; i++) begin
                a = addr + ADDRL'(i);
                addr_q.push_back(a);
                e.data = mem[a];
                e.last = (i == len - 1);
                exp_q.push_back(e);
            end
        end
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.length     = LENW'(len);
        start_cyc      = cyc;
        $display("start addr=%04h len=%0d cycle=%0d", addr, len, cyc);
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while (dones == 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("done_within_budget", dones, 1);
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_ram_enb"}, 32'(bus.ram_enb), 0);
        chk({tag, "_ram_addrb"}, 32'(bus.ram_addrb), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 0);
        chk({tag, "_out_last"}, 32'(bus.out_last), 0);
    endtask

    task automatic check_complete(input string tag, input int n);
        chk({tag, "_pops"}, pops, n);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
        chk({tag, "_addr_left"}, addr_q.size(), 0);
    endtask

    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 8'hA0 + 8'(i);
        mem[14'h3FFE] = 8'h11;
        mem[14'h3FFF] = 8'h22;
        mem[14'h0000] = 8'h33;
        mem[14'h0001] = 8'h44;
        for (int i = 0; i < 16; i++) mem[16'h0200 + i] = 8'h50 + 8'(i);
        mem[14'h0100] = 8'hC1;
        mem[14'h0101] = 8'hC2;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0300 + i] = 8'h70 + 8'(i);
            mem[16'h0380 + i] = 8'hE0 + 8'(i);
        end
        clear_model();

        // Reset state
        #2;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Nominal 4-byte transfer with latency checks
        clear_model();
        start_xfer(14'h0010, 4, 1'b1);
        run_done(50);
        check_complete("nominal", 4);
        chk("nominal_first_enb", first_enb, start_cyc + 1);
        chk("nominal_first_valid", first_valid, start_cyc + 3);
        chk("nominal_last_pop", last_pop, first_valid + 3);
        chk("nominal_done_cycle", done_c, last_pop + 1);

        // Backpressure: ready pattern applied from the first valid cycle
        clear_model();
        start_xfer(14'h0010, 4, 1'b1);
        for (int i = 0; i < 60 && dones == 0; i++) begin
            bus.out_ready = (i >= 2 && i < 9) ? pat[i-2][0] : 1'b1;
            cycle();
        end
        bus.out_ready = 1'b1;
        run_done(20);
        check_complete("backpressure", 4);

        // Address wrap at the top of the buffer
        clear_model();
        start_xfer(14'h3FFE, 4, 1'b1);
        run_done(50);
        check_complete("wrap", 4);

        // Zero length
        clear_model();
        start_xfer(14'h0020, 0, 1'b1);
        chk("zero_done_next", 32'(bus.done), 1);
        chk("zero_busy_next", 32'(bus.busy), 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("zero_enbs", enbs, 0);
        chk("zero_valids", valids, 0);
        chk("zero_busys", busys, 0);
        chk("zero_dones", dones, 1);

        // Reset after the 5th byte of a 16-byte transfer
        clear_model();
        start_xfer(14'h0200, 16, 1'b1);
        for (int i = 0; i < 100 && pops < 5; i++) cycle();
        chk("pops_before_reset", pops, 5);
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        clear_model();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        start_xfer(14'h0100, 2, 1'b1);
        run_done(50);
        check_complete("after_reset", 2);

        // Start while busy is ignored
        clear_model();
        start_xfer(14'h0300, 8, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        chk("busy_during_xfer", 32'(bus.busy), 1);
        start_xfer(14'h0380, 8, 1'b0);
        run_done(60);
        for (int i = 0; i < 6; i++) cycle();
        check_complete("start_busy", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
